// File: rtl/coffee_key_pio.sv
// Coffee-machine front-panel key input port on the s1-style Avalon-MM slave bus.
// Each key is synchronised, debounced and edge-detected. Selected edges latch into a
// sticky write-1-to-clear capture register that drives a maskable level interrupt.
module coffee_key_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter int unsigned IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic        IDLE_BIT = 1'(IDLE_LEVEL);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] deb_d;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;

    logic             wr_en_c;
    logic [WIDTH-1:0] edge_c;
    logic [WIDTH-1:0] clr_c;
    logic             unused_wdata;

    // Upper writedata bits beyond WIDTH carry no meaning for this port.
    assign unused_wdata = ^writedata;

    assign wr_en_c = chipselect & ~write_n;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= IDLE_VEC;
            sync2 <= IDLE_VEC;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a new level is accepted only after DEBOUNCE_CYCLES mismatching cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debounced <= IDLE_VEC;
            deb_d     <= IDLE_VEC;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= debounced;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == debounced[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    debounced[i] <= sync2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge selection on the debounced level and W1C clear decode.
    always_comb begin
        edge_c = '0;
        clr_c  = '0;
        case (EDGE_TYPE)
            0:       edge_c = debounced & ~deb_d;
            1:       edge_c = ~debounced & deb_d;
            default: edge_c = debounced ^ deb_d;
        endcase
        if (wr_en_c && (address == ADDR_EDGECAP)) begin
            clr_c = writedata[WIDTH-1:0];
        end
    end

    // Interrupt mask, sticky edge capture (set wins over clear) and registered irq.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_en_c && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecap <= (edgecap & ~clr_c) | edge_c;
            irq     <= |(edgecap & irqmask);
        end
    end

    // Zero-latency read mux; unmapped addresses read zero.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(debounced);
            ADDR_IRQMASK: readdata = 32'(irqmask);
            ADDR_EDGECAP: readdata = 32'(edgecap);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_coffee_key_pio.sv
// Directed bench for coffee_key_pio: register-map table plus hand sequences for
// debounce latency, glitch rejection, irq masking, set-vs-clear race and mid-debounce reset.
module tb_coffee_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    coffee_key_pio #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (1),
        .IDLE_LEVEL     (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(name, readdata, exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'b0, irq}, {31'b0, exp});
    endtask

    task automatic bus_write(input logic cs, input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            cs    wr    addr  wdata          exp_rd
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0,         32'h0000000F};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h00000000};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 32'hFFFFFFFF,  32'h0000000F};
        vecs[3] = '{1'b0, 1'b1, 2'd2, 32'h00000000,  32'h0000000F};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h12345678,  32'h00000000};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h00000000,  32'h0000000F};
        vecs[6] = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF,  32'h00000000};
        vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h00000005,  32'h00000005};
        vecs[8] = '{1'b1, 1'b1, 2'd2, 32'h00000000,  32'h00000000};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state.
        check_reg("reset_data",    2'd0, 32'hF);
        check_reg("reset_irqmask", 2'd2, 32'h0);
        check_reg("reset_edgecap", 2'd3, 32'h0);
        check_irq("reset_irq", 1'b0);

        // Register map table.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].wr) begin
                bus_write(vecs[v].cs, vecs[v].addr, vecs[v].wdata);
            end
            check_reg($sformatf("regmap_vec%0d", v), vecs[v].addr, vecs[v].exp_rd);
        end

        // Bit 0 falling: DATA changes exactly 6 clocks after the input.
        tick(1);
        in_port = 4'hE;
        tick(5);
        check_reg("deb_latency_5", 2'd0, 32'hF);
        tick(1);
        check_reg("deb_latency_6", 2'd0, 32'hE);
        tick(1);
        check_reg("edgecap_bit0", 2'd3, 32'h1);
        tick(2);
        check_irq("irq_masked_off", 1'b0);

        // Bit 1 glitch of 3 clocks is rejected.
        in_port = 4'hC;
        tick(3);
        in_port = 4'hE;
        tick(6);
        check_reg("glitch_data",    2'd0, 32'hE);
        check_reg("glitch_edgecap", 2'd3, 32'h1);

        // Counter was cleared by the glitch: a real change still needs the full 6 clocks.
        in_port = 4'hC;
        tick(5);
        check_reg("post_glitch_5", 2'd0, 32'hE);
        tick(1);
        check_reg("post_glitch_6", 2'd0, 32'hC);
        tick(1);
        check_reg("edgecap_bit01", 2'd3, 32'h3);

        // Mask write with a captured edge raises irq one cycle after the mask update.
        bus_write(1'b1, 2'd2, 32'h1);
        check_irq("irq_mask_write_edge", 1'b0);
        tick(1);
        check_irq("irq_after_mask", 1'b1);
        bus_write(1'b1, 2'd3, 32'h1);
        tick(1);
        check_reg("w1c_bit0", 2'd3, 32'h2);
        check_irq("irq_after_w1c", 1'b0);
        bus_write(1'b1, 2'd3, 32'hF);
        check_reg("w1c_all", 2'd3, 32'h0);

        // W1C of bit 2 on the same edge that captures bit 2: set wins.
        in_port = 4'h8;
        tick(6);
        check_reg("bit2_data", 2'd0, 32'h8);
        bus_write(1'b1, 2'd3, 32'h4);
        check_reg("set_wins", 2'd3, 32'h4);
        tick(1);
        check_reg("set_wins_sticky", 2'd3, 32'h4);
        check_irq("irq_bit2_unmasked", 1'b0);

        // Release all keys: rising edges are not captured.
        in_port = 4'hF;
        tick(6);
        check_reg("release_data", 2'd0, 32'hF);
        tick(1);
        check_reg("release_edgecap", 2'd3, 32'h4);
        bus_write(1'b1, 2'd3, 32'hF);
        bus_write(1'b1, 2'd2, 32'hF);
        tick(1);
        check_irq("irq_all_clear", 1'b0);

        // Reset in the middle of debouncing bit 3.
        in_port = 4'h7;
        tick(4);
        reset_n = 1'b0;
        in_port = 4'hF;
        tick(1);
        check_reg("midrst_data",    2'd0, 32'hF);
        check_reg("midrst_irqmask", 2'd2, 32'h0);
        check_reg("midrst_edgecap", 2'd3, 32'h0);
        check_irq("midrst_irq", 1'b0);
        reset_n = 1'b1;
        tick(8);
        check_reg("post_rst_data",    2'd0, 32'hF);
        check_reg("post_rst_edgecap", 2'd3, 32'h0);
        check_irq("post_rst_irq", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
